sw_ingress_fsm: RTL and testbench

//  Ingress frame FSM for one switch input, successor of the single-port input FSM.

---
 rtl/sw_pkg.sv | 25 ++
 rtl/sw_wdog_cnt.sv | 42 ++++
 rtl/sw_ingress_fsm.sv | 174 +++++++++++++++++
 tb/tb_sw_ingress_fsm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared definitions for the switch ingress path: FSM state encoding,
// default start-of-frame marker and a select-index width helper.
package sw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SOF_WAIT,
        ADDR,
        DATA,
        EOF
    } state_e;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hFF;

    // Width of an index able to address n items; never narrower than 1 bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sw_wdog_cnt.sv
// SOF watchdog counter: synchronous clear, increment, and a flag that is
// high while the count sits on its terminal value WDOG_CYCLES-1.
module sw_wdog_cnt
    import sw_pkg::*;
#(
    parameter int WDOG_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int CNT_W = clog2(WDOG_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(WDOG_CYCLES - 1));

endmodule

// File: rtl/sw_ingress_fsm.sv
// Ingress frame FSM for one switch input port. Hunts for SOF under a
// watchdog, decodes the address byte against N_PORTS port addresses
// (lowest index wins) and steers payload writes to the matched FIFO.
// All outputs are registered. wr_en is high for every DATA cycle,
// including the closing cycle where sw_en is low; the FIFO qualifies
// its write with sw_en.
// Optional feature macro: PARITY_CHECK_EN enables the payload XOR check
// driving parity_err; without it parity_err is constant 0.
module sw_ingress_fsm
    import sw_pkg::*;
#(
    parameter int                 W_WIDTH     = 8,
    parameter int                 N_PORTS     = 4,
    parameter logic [W_WIDTH-1:0] SOF_BYTE    = W_WIDTH'(SOF_BYTE_DEFAULT),
    parameter int                 WDOG_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sw_en,
    input  logic [W_WIDTH-1:0]         data_in,
    input  logic [N_PORTS*W_WIDTH-1:0] port_addr,
    input  logic [N_PORTS-1:0]         port_busy,
    output logic [N_PORTS-1:0]         wr_en,
    output logic                       frame_done,
    output logic                       frame_drop,
    output logic                       wdog_to,
    output logic                       parity_err
);

    localparam int SEL_W = clog2(N_PORTS);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   match_idx;
    logic               match_any;
    logic               sof_hit;
    logic               wdog_tc;
    logic               cnt_clr;
    logic               cnt_inc;

    logic [N_PORTS-1:0] wr_en_q, wr_en_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_drop_q, frame_drop_d;
    logic               wdog_to_q, wdog_to_d;

    assign sof_hit = (data_in == SOF_BYTE);

    // The watchdog only runs while hunting for SOF; it restarts on every entry.
    assign cnt_clr = (state_q != SOF_WAIT) || sof_hit || wdog_tc;
    assign cnt_inc = !cnt_clr;

    sw_wdog_cnt #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(cnt_clr),
        .inc_i(cnt_inc),
        .tc_o (wdog_tc)
    );

    // Address decode with lowest-index priority: scanning downward lets the
    // last (lowest) match overwrite any higher one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        match_any = 1'b0;
        match_idx = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (data_in == port_addr[i*W_WIDTH +: W_WIDTH]) begin
                match_any = 1'b1;
                match_idx = SEL_W'(i);
            end
        end
    end

    // Next-state logic and port selection.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (sw_en) state_d = SOF_WAIT;
            end
            SOF_WAIT: begin
                // SOF seen on the terminal count still wins over the timeout.
                if (sof_hit)      state_d = ADDR;
                else if (wdog_tc) state_d = IDLE;
            end
            ADDR: begin
                if (!match_any || port_busy[match_idx]) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    sel_d   = match_idx;
                end
            end
            DATA: begin
                // Busy on the selected port outranks a simultaneous frame end.
                if (port_busy[sel_q]) state_d = IDLE;
                else if (!sw_en)      state_d = EOF;
            end
            EOF: begin
                state_d = sw_en ? SOF_WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the transition being taken this cycle.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            wr_en_d[i] = (state_d == DATA) && (sel_d == SEL_W'(i));
        end
        frame_done_d = (state_q == DATA) && (state_d == EOF);
        frame_drop_d = ((state_q == ADDR) || (state_q == DATA)) && (state_d == IDLE);
        wdog_to_d    = (state_q == SOF_WAIT) && (state_d == IDLE);
    end

    // State, selection and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            wr_en_q      <= '0;
            frame_done_q <= 1'b0;
            frame_drop_q <= 1'b0;
            wdog_to_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            frame_drop_q <= frame_drop_d;
            wdog_to_q    <= wdog_to_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign frame_done = frame_done_q;
    assign frame_drop = frame_drop_q;
    assign wdog_to    = wdog_to_q;

`ifdef PARITY_CHECK_EN
    logic [W_WIDTH-1:0] acc_q, acc_d;
    logic               parity_err_q, parity_err_d;

    // Running XOR over payload bytes; the trailing parity byte brings a good frame to zero.
    always_comb begin
        acc_d = acc_q;
        if ((state_q == ADDR) && (state_d == DATA)) begin
            acc_d = '0;
        end else if ((state_q == DATA) && sw_en) begin
            acc_d = acc_q ^ data_in;
        end
        parity_err_d = frame_done_d && (acc_q != '0);
    end

    // Accumulator and parity error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            parity_err_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sw_ingress_fsm.sv
// Directed testbench for sw_ingress_fsm. Inputs change on the falling
// edge; outputs are compared on the following falling edge, after the
// rising edge that consumed those inputs.
module tb_sw_ingress_fsm;

`ifdef PARITY_CHECK_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        sw_en;
    logic [7:0]  data_in;
    logic [31:0] port_addr;
    logic [3:0]  port_busy;
    logic [3:0]  wr_en;
    logic        frame_done;
    logic        frame_drop;
    logic        wdog_to;
    logic        parity_err;
    logic [7:0]  outs;

    int n_checks = 0;
    int n_fail   = 0;

    sw_ingress_fsm #(
        .W_WIDTH    (8),
        .N_PORTS    (4),
        .SOF_BYTE   (8'hFF),
        .WDOG_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_en     (sw_en),
        .data_in   (data_in),
        .port_addr (port_addr),
        .port_busy (port_busy),
        .wr_en     (wr_en),
        .frame_done(frame_done),
        .frame_drop(frame_drop),
        .wdog_to   (wdog_to),
        .parity_err(parity_err)
    );

    // Output bundle: {wr_en[3:0], frame_done, frame_drop, wdog_to, parity_err}
    assign outs = {wr_en, frame_done, frame_drop, wdog_to, parity_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input cycle and move to the next falling edge.
    task automatic drive(input logic en, input logic [7:0] d);
        sw_en   = en;
        data_in = d;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sw_en = 1'b0; data_in = 8'h00;
        port_addr = {8'h03, 8'h02, 8'h01, 8'h00}; port_busy = 4'b0000;
        #2;
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL reset_held: got %b expected %b", outs, 8'h00); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL reset_release: got %b expected %b", outs, 8'h00); end
    endtask

    task automatic test_good_frame;
        drive(1'b1, 8'h00);
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL good_sofwait: got %b expected %b", outs, 8'h00); end
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'h02);
        n_checks++; if (outs !== 8'b0100_0000) begin n_fail++; $display("FAIL good_wr0: got %b expected %b", outs, 8'b0100_0000); end
        drive(1'b1, 8'h0A);
        n_checks++; if (outs !== 8'b0100_0000) begin n_fail++; $display("FAIL good_wr1: got %b expected %b", outs, 8'b0100_0000); end
        drive(1'b1, 8'h0B);
        n_checks++; if (outs !== 8'b0100_0000) begin n_fail++; $display("FAIL good_wr2: got %b expected %b", outs, 8'b0100_0000); end
        drive(1'b1, 8'h0C);
        drive(1'b0, 8'h00);
        // 0A^0B^0C = 0D, non-zero, so parity flags when the check is built in
        n_checks++; if (outs !== {4'b0000, 1'b1, 1'b0, 1'b0, PAR_ON}) begin n_fail++; $display("FAIL good_done: got %b expected %b", outs, {4'b0000, 1'b1, 1'b0, 1'b0, PAR_ON}); end
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL good_pulse_end: got %b expected %b", outs, 8'h00); end
    endtask

    task automatic test_no_match;
        drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'h07);
        n_checks++; if (outs !== 8'b0000_0100) begin n_fail++; $display("FAIL nomatch_drop: got %b expected %b", outs, 8'b0000_0100); end
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL nomatch_pulse_end: got %b expected %b", outs, 8'h00); end
    endtask

    task automatic test_busy;
        drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'h01);
        n_checks++; if (outs !== 8'b0010_0000) begin n_fail++; $display("FAIL busy_wr: got %b expected %b", outs, 8'b0010_0000); end
        port_busy = 4'b1101;
        drive(1'b1, 8'hAA);
        n_checks++; if (outs !== 8'b0010_0000) begin n_fail++; $display("FAIL busy_other_ignored: got %b expected %b", outs, 8'b0010_0000); end
        port_busy = 4'b0010;
        drive(1'b1, 8'hBB);
        n_checks++; if (outs !== 8'b0000_0100) begin n_fail++; $display("FAIL busy_drop: got %b expected %b", outs, 8'b0000_0100); end
        port_busy = 4'b0000;
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL busy_idle: got %b expected %b", outs, 8'h00); end
        // busy and sw_en falling together
        drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'h01); drive(1'b1, 8'hAA);
        port_busy = 4'b0010;
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== 8'b0000_0100) begin n_fail++; $display("FAIL busy_and_end: got %b expected %b", outs, 8'b0000_0100); end
        port_busy = 4'b0000;
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL busy_and_end_idle: got %b expected %b", outs, 8'h00); end
        // matched port already busy at address time
        port_busy = 4'b0100;
        drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'h02);
        n_checks++; if (outs !== 8'b0000_0100) begin n_fail++; $display("FAIL busy_at_addr: got %b expected %b", outs, 8'b0000_0100); end
        port_busy = 4'b0000;
        drive(1'b0, 8'h00);
    endtask

    task automatic test_watchdog;
        logic [7:0] exp;
        drive(1'b1, 8'h00);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 8'h00);
            exp = (i == 16) ? 8'b0000_0010 : 8'h00;
            n_checks++; if (outs !== exp) begin n_fail++; $display("FAIL wdog_cycle%0d: got %b expected %b", i, outs, exp); end
        end
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL wdog_pulse_end: got %b expected %b", outs, 8'h00); end
        // SOF on the 16th cycle beats the timeout
        drive(1'b1, 8'h00);
        for (int i = 1; i <= 15; i++) drive(1'b1, 8'h00);
        drive(1'b1, 8'hFF);
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL wdog_sof_last: got %b expected %b", outs, 8'h00); end
        drive(1'b1, 8'h07);
        n_checks++; if (outs !== 8'b0000_0100) begin n_fail++; $display("FAIL wdog_sof_addr: got %b expected %b", outs, 8'b0000_0100); end
        drive(1'b0, 8'h00);
    endtask

    task automatic test_back_to_back;
        port_addr = {8'h05, 8'h02, 8'h05, 8'h00};
        drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'h05);
        n_checks++; if (outs !== 8'b0010_0000) begin n_fail++; $display("FAIL dup_lowest: got %b expected %b", outs, 8'b0010_0000); end
        drive(1'b1, 8'h11);
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== {4'b0000, 1'b1, 1'b0, 1'b0, PAR_ON}) begin n_fail++; $display("FAIL b2b_done1: got %b expected %b", outs, {4'b0000, 1'b1, 1'b0, 1'b0, PAR_ON}); end
        drive(1'b1, 8'h00);
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL b2b_eof: got %b expected %b", outs, 8'h00); end
        drive(1'b1, 8'hFF); drive(1'b1, 8'h02);
        n_checks++; if (outs !== 8'b0100_0000) begin n_fail++; $display("FAIL b2b_wr2: got %b expected %b", outs, 8'b0100_0000); end
        drive(1'b1, 8'h33);
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== {4'b0000, 1'b1, 1'b0, 1'b0, PAR_ON}) begin n_fail++; $display("FAIL b2b_done2: got %b expected %b", outs, {4'b0000, 1'b1, 1'b0, 1'b0, PAR_ON}); end
        drive(1'b0, 8'h00);
        port_addr = {8'h03, 8'h02, 8'h01, 8'h00};
    endtask

    task automatic test_parity;
        drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'h00);
        n_checks++; if (outs !== 8'b0001_0000) begin n_fail++; $display("FAIL par_wr0: got %b expected %b", outs, 8'b0001_0000); end
        drive(1'b1, 8'h11); drive(1'b1, 8'h22); drive(1'b1, 8'h33);
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== 8'b0000_1000) begin n_fail++; $display("FAIL par_good: got %b expected %b", outs, 8'b0000_1000); end
        drive(1'b0, 8'h00);
        drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'h00);
        drive(1'b1, 8'h11); drive(1'b1, 8'h22); drive(1'b1, 8'h34);
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== {4'b0000, 1'b1, 1'b0, 1'b0, PAR_ON}) begin n_fail++; $display("FAIL par_bad: got %b expected %b", outs, {4'b0000, 1'b1, 1'b0, 1'b0, PAR_ON}); end
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL par_pulse_end: got %b expected %b", outs, 8'h00); end
        // aborted frame with non-zero accumulator: drop only
        drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'h00); drive(1'b1, 8'h11);
        port_busy = 4'b0001;
        drive(1'b1, 8'h22);
        n_checks++; if (outs !== 8'b0000_0100) begin n_fail++; $display("FAIL par_abort: got %b expected %b", outs, 8'b0000_0100); end
        port_busy = 4'b0000;
        drive(1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_frame;
        drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'h01);
        n_checks++; if (outs !== 8'b0010_0000) begin n_fail++; $display("FAIL rst_pre: got %b expected %b", outs, 8'b0010_0000); end
        drive(1'b1, 8'h55);
        rst_n = 1'b0;
        #1;
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL rst_async: got %b expected %b", outs, 8'h00); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== 8'h00) begin n_fail++; $display("FAIL rst_no_pulse: got %b expected %b", outs, 8'h00); end
        drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'h02);
        n_checks++; if (outs !== 8'b0100_0000) begin n_fail++; $display("FAIL rst_recover: got %b expected %b", outs, 8'b0100_0000); end
        drive(1'b0, 8'h00);
        n_checks++; if (outs !== 8'b0000_1000) begin n_fail++; $display("FAIL rst_recover_done: got %b expected %b", outs, 8'b0000_1000); end
        drive(1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_no_match();
        test_busy();
        test_watchdog();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
